// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: selects two sources from the register bank,
// tracks in-flight destinations and forwards same-cycle write-backs.
module operand_fetch_unit #(
   parameter int unsigned STALL_W   = 8,
   parameter bit          BYPASS_EN = 1'b1
) (
   input  logic               Clock,
   input  logic               reset,
   input  logic [255:0]       RegFlat,
   input  logic [4:0]         WbSel,
   input  logic [15:0]        WbData,
   input  logic               ReqValid,
   output logic               ReqReady,
   input  logic [3:0]         ReqSrcA,
   input  logic [3:0]         ReqSrcB,
   input  logic [4:0]         ReqDst,
   output logic               OpValid,
   input  logic               OpReady,
   output logic [15:0]        OpA,
   output logic [15:0]        OpB,
   output logic [4:0]         OpDst,
   output logic [15:0]        BusyMask,
   output logic [STALL_W-1:0] StallCount
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]  state;
   logic [0:0]  state_nxt;
   logic [15:0] wb_hit;
   logic [15:0] dst_set;
   logic [15:0] busy_nxt;
   logic [15:0] fwd_a;
   logic [15:0] fwd_b;
   logic        haz_a;
   logic        haz_b;
   logic        haz_d;
   logic        slot_free;
   logic        accept;
   logic        drain;
   logic        stall;

   always_comb begin
      wb_hit = '0;
      if (!WbSel[4])
         wb_hit[WbSel[3:0]] = 1'b1;
   end

   // A busy source is only safe when its write-back lands this cycle
   assign haz_a = BusyMask[ReqSrcA] &&
                  !(BYPASS_EN && wb_hit[ReqSrcA]);
   assign haz_b = BusyMask[ReqSrcB] &&
                  !(BYPASS_EN && wb_hit[ReqSrcB]);
   assign haz_d = !ReqDst[4] &&
                  BusyMask[ReqDst[3:0]] &&
                  !wb_hit[ReqDst[3:0]];

   assign slot_free = (state == EMPTY) || OpReady;
   assign ReqReady  = reset && slot_free &&
                      !haz_a && !haz_b && !haz_d;
   assign accept    = ReqValid && ReqReady;
   assign drain     = !accept && (state == FULL) && OpReady;
   assign stall     = ReqValid && slot_free &&
                      (haz_a || haz_b || haz_d);

   // The bank has not updated yet, so a matching write-back wins
   assign fwd_a = wb_hit[ReqSrcA] ? WbData
                                  : RegFlat[{ReqSrcA, 4'h0} +: 16];
   assign fwd_b = wb_hit[ReqSrcB] ? WbData
                                  : RegFlat[{ReqSrcB, 4'h0} +: 16];

   always_comb begin
      dst_set = '0;
      if (accept && !ReqDst[4])
         dst_set[ReqDst[3:0]] = 1'b1;
   end

   assign busy_nxt = (BusyMask & ~wb_hit) | dst_set;

   always_comb begin
      state_nxt = state;
      unique case (1'b1)
         accept:  state_nxt = FULL;
         drain:   state_nxt = EMPTY;
         default: state_nxt = state;
      endcase
   end

   assign OpValid = (state == FULL);

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state    <= EMPTY;
         OpA      <= '0;
         OpB      <= '0;
         OpDst    <= 5'h1F;
         BusyMask <= '0;
      end else begin
         state    <= state_nxt;
         BusyMask <= busy_nxt;
         if (accept) begin
            OpA   <= fwd_a;
            OpB   <= fwd_b;
            OpDst <= ReqDst;
         end
      end
   end

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset)
         StallCount <= '0;
      else if (stall && !(&StallCount))
         StallCount <= StallCount + 1'b1;
   end

endmodule
